bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  Round-robin arbiter that shares the single system bus between up to NUM_MASTERS bus masters
//  (DMA engines, CPU bridge, ...). It owns the request/granted handshake of every master.
//  It tracks transaction boundaries by snooping the shared bus (begin/end_transaction, error).
//  A watchdog recovers the bus when a master stalls.
// PARAMETERS
//  NUM_MASTERS    4    number of requesters, 2..16
//  TIMEOUT_CYCLES 255  watchdog limit in cycles, 1..65535 (used only with ARB_WATCHDOG_EN)
// PORTS
//  clock              in   1            system clock, all state on rising edge
//  reset              in   1            asynchronous, active-low reset
//  request            in   NUM_MASTERS  request[i]=1: master i wants the bus (level, held until granted)
//  granted            out  NUM_MASTERS  one-hot grant, registered
//  begin_transactionIN in  1            bus snoop: transaction start
//  end_transactionIN  in   1            bus snoop: transaction end
//  errorIN            in   1            bus snoop: bus error
//  errorOUT           out  1            1-cycle pulse: watchdog timeout, drives bus error line
//  bus_idle           out  1            1 when no master holds the bus (state IDLE)
//  active_master      out  clog2(N)     index of granted master, 0 when none
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state IDLE, granted=0, errorOUT=0, bus_idle=1, active_master=0,
//    rr pointer=NUM_MASTERS-1 (so master 0 wins the first arbitration), watchdog=0.
//  FSM states: IDLE, GRANT, BUSY, RELEASE.
//  IDLE: if |request, pick the first set bit searching ptr+1, ptr+2, ... mod N.
//    Next edge: granted[w]=1, ptr<=w, state GRANT. Latency request->granted is 1 cycle.
//  GRANT: granted held.
//    begin_transactionIN=1 -> BUSY.
//    request[w] dropped before begin -> RELEASE.
//    begin and request drop in the same cycle -> BUSY (begin wins).
//  BUSY: granted held.
//    end_transactionIN=1 -> RELEASE.
//    errorIN=1 -> RELEASE.
//    end and error in the same cycle -> RELEASE (same result).
//  RELEASE: granted=0 for exactly 1 cycle, then IDLE.
//    Bus turnaround: end at cycle k, grant low at k+1, IDLE at k+2, next grant at k+3.
//  errorIN in GRANT -> RELEASE. errorIN in IDLE/RELEASE is ignored.
//  Requests arriving during GRANT/BUSY/RELEASE wait. Arbitration happens only in IDLE.
//  Round-robin guarantees each continuously requesting master is granted within N arbitrations.
//  Request deasserted by a non-granted master: no effect.
//  At most one granted bit is ever 1. granted is never driven combinationally from request.
//  active_master equals the encoded granted index in GRANT/BUSY, 0 otherwise.
//  Reset asserted mid-transaction: granted drops immediately (asynchronous). No errorOUT pulse.
// CONFIGURATION
//  ARB_WATCHDOG_EN defined:
//    16-bit counter cleared on entry to GRANT and on every cycle end_transactionIN/begin is seen;
//    it increments each cycle in GRANT or BUSY.
//    When counter == TIMEOUT_CYCLES-1 while still in GRANT/BUSY: errorOUT=1 for one cycle and
//    state -> RELEASE. The granted master sees the error on the bus and aborts.
//  ARB_WATCHDOG_EN undefined: no counter. errorOUT is tied 0.
//    GRANT/BUSY wait indefinitely for begin/end/error.
// TESTING
//  1 reset; request=4'b1111 -> granted=4'b0001 one cycle later; begin, then end 3 cycles later;
//    granted=0 at k+1; granted=4'b0010 at k+3.
//  2 request=4'b1111 held, 8 back-to-back transactions -> grant order 0,1,2,3,0,1,2,3;
//    never two granted bits set.
//  3 request=4'b0100 only, ptr=2 -> re-granted to 2. Then add request[0] -> master 0 next,
//    not 2 again.
//  4 grant to master 1, drop request[1] before begin -> RELEASE, granted=0 next cycle,
//    no errorOUT.
//  5 WATCHDOG_EN, TIMEOUT_CYCLES=16: grant, begin, no end -> errorOUT pulse 16 cycles after
//    begin, granted=0 next cycle. Without macro: grant held for 1000 cycles.
//  6 reset=0 during BUSY -> granted=0 asynchronously, bus_idle=1.
//    After release, request=4'b1000 -> granted=4'b1000.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter.
//
// Shares one system bus between NUM_MASTERS masters. Arbitration runs only while the bus is idle.
// A grant is held until the snooped transaction ends, a bus error is seen, the granted master
// withdraws its request before starting, or (optionally) the watchdog expires.
//
// Optional feature macro: ARB_WATCHDOG_EN
//   defined   : a 16-bit watchdog aborts a stalled grant and pulses errorOUT for one cycle.
//   undefined : no watchdog; errorOUT is tied low.
//
// Ports:
//   clock               in   system clock, rising edge
//   reset               in   asynchronous active-low reset
//   request             in   per-master bus request (level)
//   granted             out  one-hot registered grant
//   begin_transactionIN in   snooped transaction start
//   end_transactionIN   in   snooped transaction end
//   errorIN             in   snooped bus error
//   errorOUT            out  watchdog timeout pulse
//   bus_idle            out  high while no master owns the bus
//   active_master       out  index of the granted master, 0 when none
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned IdxW          = $clog2(NUM_MASTERS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] granted,
  input  logic                   begin_transactionIN,
  input  logic                   end_transactionIN,
  input  logic                   errorIN,
  output logic                   errorOUT,
  output logic                   bus_idle,
  output logic [IdxW-1:0]        active_master
);

  typedef enum logic [1:0] {StIdle, StGrant, StBusy, StRelease} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] granted_q, granted_d;
  // Last winner; while the bus is held it is also the owner's index.
  logic [IdxW-1:0]        ptr_q, ptr_d;

  logic                   found;
  logic [IdxW-1:0]        winner;
  logic [IdxW-1:0]        cand;
  logic                   held;
  logic                   timeout;

  assign held = (state_q == StGrant) || (state_q == StBusy);

  // Search ptr+1, ptr+2, ... (mod N) for the first requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NUM_MASTERS);
      if (!found && request[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;

  assign timeout  = held && (wd_q == 16'(TIMEOUT_CYCLES - 1));
  assign errorOUT = timeout;

  always_comb begin
    wd_d = wd_q;
    if (state_q == StIdle) begin
      wd_d = '0;
    end else if (held) begin
      if (begin_transactionIN || end_transactionIN) wd_d = '0;
      else                                          wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign timeout  = 1'b0;
  assign errorOUT = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    granted_d = granted_q;
    ptr_d     = ptr_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d   = StGrant;
          granted_d = NUM_MASTERS'(1) << winner;
          ptr_d     = winner;
        end
      end
      StGrant: begin
        // Watchdog beats a late begin; begin beats a request drop.
        if (timeout) begin
          state_d   = StRelease;
          granted_d = '0;
        end else if (begin_transactionIN) begin
          state_d = StBusy;
        end else if (!request[ptr_q] || errorIN) begin
          state_d   = StRelease;
          granted_d = '0;
        end
      end
      StBusy: begin
        if (timeout || end_transactionIN || errorIN) begin
          state_d   = StRelease;
          granted_d = '0;
        end
      end
      StRelease: begin
        state_d   = StIdle;
        granted_d = '0;
      end
      default: begin
        state_d   = StIdle;
        granted_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      granted_q <= '0;
      ptr_q     <= IdxW'(NUM_MASTERS - 1);
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      ptr_q     <= ptr_d;
    end
  end

  assign granted       = granted_q;
  assign bus_idle      = (state_q == StIdle);
  assign active_master = held ? ptr_q : '0;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: a transaction-level model of bus ownership checked
// every cycle, plus hand-computed directed expectations.
module tb_bus_arbiter_rr;

  localparam int N = 4;
  localparam int T = 16;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic [N-1:0] request;
  logic [N-1:0] granted;
  logic         begin_tx;
  logic         end_tx;
  logic         err_in;
  logic         err_out;
  logic         bus_idle;
  logic [1:0]   active_master;

  int checks;
  int errors;

  bus_arbiter_rr #(
    .NUM_MASTERS   (N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .request            (request),
    .granted            (granted),
    .begin_transactionIN(begin_tx),
    .end_transactionIN  (end_tx),
    .errorIN            (err_in),
    .errorOUT           (err_out),
    .bus_idle           (bus_idle),
    .active_master      (active_master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of bus ownership: who owns the bus, whether their transaction started, whether the
  // bus is in its one-cycle turnaround, who won last, and cycles since the last activity.
  int m_owner, m_last, m_wd;
  bit m_held, m_started, m_cool, m_stop;

  function automatic bit req_bit(input int k);
    return ((request >> k) & 4'd1) != 4'd0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_held = 0; m_started = 0; m_cool = 0; m_owner = 0; m_last = N - 1; m_wd = 0;
    end else if (m_cool) begin
      m_cool = 0;
    end else if (!m_held) begin
      for (int d = 1; d <= N; d++) begin
        if (req_bit((m_last + d) % N)) begin
          m_owner = (m_last + d) % N; m_last = m_owner;
          m_held = 1; m_started = 0; m_wd = 0;
          break;
        end
      end
    end else begin
      m_stop = WD && (m_wd == T - 1);
      if (!m_stop) begin
        if (!m_started) begin
          if (begin_tx) m_started = 1;
          else if (!req_bit(m_owner) || err_in) m_stop = 1;
        end else if (end_tx || err_in) begin
          m_stop = 1;
        end
      end
      m_wd = (begin_tx || end_tx) ? 0 : m_wd + 1;
      if (m_stop) begin m_held = 0; m_started = 0; m_cool = 1; end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("model_granted", 32'(granted), m_held ? (32'd1 << m_owner) : 32'd0);
      check("model_active_master", 32'(active_master), m_held ? 32'(m_owner) : 32'd0);
      check("model_bus_idle", 32'(bus_idle), 32'(!m_held && !m_cool));
      check("model_errorOUT", 32'(err_out), 32'(WD && m_held && (m_wd == T - 1)));
      check("onehot0_granted", 32'($onehot0(granted)), 32'd1);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic wait_grant(output int who);
    int n;
    n = 0;
    while (granted == '0 && n < 20) begin
      step();
      n++;
    end
    if (granted == '0) check("grant_wait_expired", 32'd0, 32'd1);
    who = idx_of(granted);
  endtask

  task automatic run_tx(output int who);
    wait_grant(who);
    begin_tx = 1'b1;
    step();
    begin_tx = 1'b0;
    end_tx   = 1'b1;
    step();
    end_tx   = 1'b0;
  endtask

  int who;
  int order[8];
  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int n;
  int pulses;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; request = '0; begin_tx = 1'b0; end_tx = 1'b0; err_in = 1'b0;
    step(); step();
    reset = 1'b1;

    // 1: reset values, first grant, turnaround
    check("rst_granted", 32'(granted), 32'd0);
    check("rst_bus_idle", 32'(bus_idle), 32'd1);
    check("rst_active_master", 32'(active_master), 32'd0);
    check("rst_errorOUT", 32'(err_out), 32'd0);
    request = 4'b1111;
    step();
    check("first_grant", 32'(granted), 32'b0001);
    begin_tx = 1'b1;
    step();
    begin_tx = 1'b0;
    step();
    step();
    end_tx = 1'b1;
    step();
    end_tx = 1'b0;
    check("release_k1_granted", 32'(granted), 32'd0);
    step();
    check("idle_k2_bus_idle", 32'(bus_idle), 32'd1);
    check("idle_k2_granted", 32'(granted), 32'd0);
    step();
    check("next_grant_k3", 32'(granted), 32'b0010);
    check("next_grant_k3_am", 32'(active_master), 32'd1);

    // 2: back-to-back round robin from fresh reset
    request = '0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    request = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      run_tx(who);
      order[i] = who;
    end
    for (int i = 0; i < 8; i++) check($sformatf("rr_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // 3: lone requester re-granted, then a new requester wins next
    request = 4'b0100;
    run_tx(who);
    check("lone_req_first", 32'(who), 32'd2);
    run_tx(who);
    check("lone_req_regrant", 32'(who), 32'd2);
    request = 4'b0101;
    run_tx(who);
    check("added_req_wins", 32'(who), 32'd0);

    // 4: granted master drops request before begin
    request = 4'b0010;
    wait_grant(who);
    check("drop_grant", 32'(granted), 32'b0010);
    request = '0;
    step();
    check("drop_release_granted", 32'(granted), 32'd0);
    check("drop_release_err", 32'(err_out), 32'd0);
    check("drop_release_idle", 32'(bus_idle), 32'd0);
    step();
    check("drop_back_idle", 32'(bus_idle), 32'd1);

    // 5: stalled transaction
    request = 4'b1000;
    wait_grant(who);
    check("stall_grant", 32'(who), 32'd3);
    begin_tx = 1'b1;
    step();
    begin_tx = 1'b0;
`ifdef ARB_WATCHDOG_EN
    n = 1;
    while (!err_out && n <= 40) begin
      step();
      n++;
    end
    check("wd_pulse_cycle", 32'(n), 32'd16);
    request = '0;
    step();
    check("wd_release_granted", 32'(granted), 32'd0);
    check("wd_pulse_width", 32'(err_out), 32'd0);
    step();
`else
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (err_out) pulses++;
    end
    check("nowd_grant_held", 32'(granted), 32'b1000);
    check("nowd_no_errorOUT", 32'(pulses), 32'd0);
    end_tx = 1'b1;
    step();
    end_tx = 1'b0;
    request = '0;
    step();
`endif

    // 6: asynchronous reset during a transaction
    request = 4'b1000;
    wait_grant(who);
    check("busy_grant", 32'(granted), 32'b1000);
    begin_tx = 1'b1;
    step();
    begin_tx = 1'b0;
    check("busy_not_idle", 32'(bus_idle), 32'd0);
    #1 reset = 1'b0;
    #1;
    check("async_rst_granted", 32'(granted), 32'd0);
    check("async_rst_bus_idle", 32'(bus_idle), 32'd1);
    check("async_rst_errorOUT", 32'(err_out), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    check("post_reset_grant", 32'(granted), 32'b1000);
    request = '0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
